// File: rtl/mux_scan_sampler_if.sv
// Scan-sampler bus: start/continuous control, mux select/return path,
// and the valid/ready word output with status flags.
interface mux_scan_sampler_if;
  logic       start;
  logic       continuous;
  logic [1:0] sel;
  logic       mux_in;
  logic [3:0] word;
  logic       word_valid;
  logic       word_ready;
  logic       busy;
  logic       overrun;

  // Driver of control, mux return and the downstream ready.
  modport master (
    output start, continuous, mux_in, word_ready,
    input  sel, word, word_valid, busy, overrun
  );

  // The sampler itself.
  modport slave (
    input  start, continuous, mux_in, word_ready,
    output sel, word, word_valid, busy, overrun
  );
endinterface

// File: rtl/mux_scan_sampler.sv
// Round-robin 4:1 mux scanner: steps sel, waits SETTLE_CYCLES, samples
// mux_in, and emits the 4-bit scan word over a valid/ready handshake.
module mux_scan_sampler #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input logic               clk,
  input logic               rst_n,
  mux_scan_sampler_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2
  } state_e;

  localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] sel_q, sel_d;
  logic [2:0] shadow_q, shadow_d;
  logic [3:0] word_q, word_d;
  logic       valid_q, valid_d;
  logic       overrun_q, overrun_d;
  logic       busy_q, busy_d;

  logic complete;
  logic xfer;

  assign complete = (state_q == SAMPLE) && (sel_q == 2'd3);
  assign xfer     = valid_q && bus.word_ready;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sel_d     = sel_q;
    shadow_d  = shadow_q;
    word_d    = word_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;

    unique case (state_q)
      IDLE: begin
        sel_d = 2'd0;
        if (bus.start) begin
          state_d = SETTLE;
          cnt_d   = 4'd0;
        end
      end
      SETTLE: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == CNT_LAST) state_d = SAMPLE;
      end
      SAMPLE: begin
        cnt_d = 4'd0;
        if (sel_q == 2'd3) begin
          // Wrap back to channel 0; continuous chains scans with no gap.
          sel_d   = 2'd0;
          state_d = bus.continuous ? SETTLE : IDLE;
        end else begin
          for (int i = 0; i < 3; i++)
            if (sel_q == 2'(i)) shadow_d[i] = bus.mux_in;
          sel_d   = sel_q + 2'd1;
          state_d = SETTLE;
        end
      end
      default: begin
        state_d = IDLE;
        sel_d   = 2'd0;
        cnt_d   = 4'd0;
      end
    endcase

    // A finished scan may replace the held word only if it is free or
    // being taken at this same edge; otherwise the new scan is lost.
    if (complete) begin
      if (!valid_q || bus.word_ready) begin
        word_d  = {bus.mux_in, shadow_q};
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (xfer) begin
      valid_d = 1'b0;
    end
  end

  assign busy_d = (state_d != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      sel_q     <= 2'd0;
      shadow_q  <= 3'd0;
      word_q    <= 4'd0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      shadow_q  <= shadow_d;
      word_q    <= word_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.sel        = sel_q;
  assign bus.word       = word_q;
  assign bus.word_valid = valid_q;
  assign bus.busy       = busy_q;
  assign bus.overrun    = overrun_q;

endmodule
